// File: rtl/clk_div_mon.sv
// Divided-clock monitor: synchronizes i_div_clk, measures high/low phase lengths
// in i_clk cycles, and flags out-of-tolerance half-periods and stuck inputs.
module clk_div_mon #(
  parameter int unsigned EXP_HALF  = 6,
  parameter int unsigned TOL       = 0,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_en,
  input  logic                 i_div_clk,
  input  logic                 i_clr_err,
  output logic                 o_rise,
  output logic                 o_fall,
  output logic [CNT_WIDTH-1:0] o_high_cnt,
  output logic [CNT_WIDTH-1:0] o_low_cnt,
  output logic                 o_meas_valid,
  output logic                 o_err_period,
  output logic                 o_err_stuck
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_hist;
  logic                 r_rise_q;
  logic                 r_fall_q;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic w_active;
  logic w_edge;
  logic w_stuck;
  logic w_period_err;

  // True when a measured half-period lies outside EXP_HALF +/- TOL.
  function automatic logic f_out_of_tol(input logic [CNT_WIDTH-1:0] val);
    int unsigned v;
    v = 32'(val);
    if (v > EXP_HALF) return (v - EXP_HALF) > TOL;
    return (EXP_HALF - v) > TOL;
  endfunction

  // Two-flop synchronizer, history flop and registered edge pulses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_hist   <= 1'b0;
      r_rise_q <= 1'b0;
      r_fall_q <= 1'b0;
    end else begin
      r_sync1  <= i_div_clk;
      r_sync2  <= r_sync1;
      r_hist   <= r_sync2;
      r_rise_q <= r_sync2 & ~r_hist;
      r_fall_q <= ~r_sync2 & r_hist;
    end
  end

  assign w_active     = i_en && (r_state != ST_IDLE);
  assign w_edge       = r_rise_q | r_fall_q;
  assign w_stuck      = w_active && !w_edge && (r_cnt == TIMEOUT_CNT);
  assign w_period_err = w_active && (r_state == ST_LOW) && r_rise_q &&
                        (f_out_of_tol(o_high_cnt) || f_out_of_tol(r_cnt));

  // Measurement FSM, run counter and strobes; an i_en drop overrides everything.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      o_rise       <= 1'b0;
      o_fall       <= 1'b0;
      o_meas_valid <= 1'b0;
      o_high_cnt   <= '0;
      o_low_cnt    <= '0;
    end else begin
      o_rise       <= 1'b0;
      o_fall       <= 1'b0;
      o_meas_valid <= 1'b0;
      if (!i_en) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else if (r_state == ST_IDLE) begin
        r_state <= ST_SYNC;
        r_cnt   <= '0;
      end else begin
        o_rise <= r_rise_q;
        o_fall <= r_fall_q;
        if (w_edge) begin
          r_cnt <= CNT_ONE;
        end else if (w_stuck) begin
          r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + CNT_ONE;
        end
        if (w_stuck) begin
          r_state <= ST_SYNC;
        end else begin
          case (r_state)
            ST_SYNC: begin
              if (r_rise_q) r_state <= ST_HIGH;
            end
            ST_HIGH: begin
              if (r_fall_q) begin
                r_state    <= ST_LOW;
                o_high_cnt <= r_cnt;
              end
            end
            ST_LOW: begin
              if (r_rise_q) begin
                r_state      <= ST_HIGH;
                o_low_cnt    <= r_cnt;
                o_meas_valid <= 1'b1;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_err_period <= 1'b0;
      o_err_stuck  <= 1'b0;
    end else begin
      if (w_period_err) o_err_period <= 1'b1;
      else if (i_clr_err) o_err_period <= 1'b0;
      if (w_stuck) o_err_stuck <= 1'b1;
      else if (i_clr_err) o_err_stuck <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_div_mon.sv
// Bench for clk_div_mon: directed scenarios plus randomized waveforms, all checked
// cycle by cycle against a timestamp-based reference model.
module tb_clk_div_mon;

  localparam int M_EXP     = 6;
  localparam int M_TOL     = 1;
  localparam int M_TIMEOUT = 20;
  localparam int M_CMAX    = 255;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_en = 1'b0;
  logic       i_div_clk = 1'b0;
  logic       i_clr_err = 1'b0;
  logic       o_rise, o_fall, o_meas_valid, o_err_period, o_err_stuck;
  logic [7:0] o_high_cnt, o_low_cnt;

  clk_div_mon #(
    .EXP_HALF (6),
    .TOL      (1),
    .CNT_WIDTH(8),
    .TIMEOUT  (20)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_en        (i_en),
    .i_div_clk   (i_div_clk),
    .i_clr_err   (i_clr_err),
    .o_rise      (o_rise),
    .o_fall      (o_fall),
    .o_high_cnt  (o_high_cnt),
    .o_low_cnt   (o_low_cnt),
    .o_meas_valid(o_meas_valid),
    .o_err_period(o_err_period),
    .o_err_stuck (o_err_stuck)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
  endtask

  // Stimulus record, keyed by the i_clk edge that samples the value.
  bit trans[int];        // 1 = level went high, 0 = went low
  bit en_at[int];
  bit clr_at[int];
  bit rst_low_at[int];
  bit clr_sched[int];
  bit prev_lvl = 1'b0;
  bit sched_clr_on_rise = 1'b0;

  logic cur_div = 1'b0, cur_en = 1'b0, cur_clr = 1'b0, cur_rstn = 1'b0;

  task automatic drive_cycle();
    int k;
    @(posedge i_clk);
    #2;
    k = cyc + 1;
    i_div_clk = cur_div;
    i_en      = cur_en;
    i_reset_n = cur_rstn;
    i_clr_err = cur_clr || (clr_sched.exists(k) != 0);
    en_at[k]      = cur_en;
    clr_at[k]     = i_clr_err;
    rst_low_at[k] = !cur_rstn;
    if (!cur_rstn) begin
      prev_lvl = 1'b0;
    end else if (cur_div != prev_lvl) begin
      trans[k] = cur_div;
      prev_lvl = cur_div;
      if (cur_div && sched_clr_on_rise) clr_sched[k+3] = 1'b1;
    end
  endtask

  task automatic hold(input int n);
    repeat (n) drive_cycle();
  endtask

  task automatic half(input logic lvl, input int len);
    cur_div = lvl;
    hold(len);
  endtask

  // Reference model: edges become visible 3 cycles after sampling; phase lengths
  // are differences of edge timestamps; the run count is time since the last reference.
  function automatic bit off_tol(input int v);
    return ((v > M_EXP) ? (v - M_EXP) : (M_EXP - v)) > M_TOL;
  endfunction

  bit m_active = 0, m_armed = 0, m_hf = 0, m_errp = 0, m_errs = 0;
  int m_high = 0, m_low = 0, m_rise_t = 0, m_fall_t = 0, m_ref_t = 0, m_ref_v = 0;
  int meas_seen = 0;

  always @(negedge i_clk) begin
    int  n, cnt_b;
    bit  en, clr, has_e, is_r, e_rise, e_fall, e_meas, setp, sets;
    if (o_meas_valid === 1'b1) meas_seen++;
    n = cyc;
    e_rise = 0; e_fall = 0; e_meas = 0; setp = 0; sets = 0;
    if (n > 0) begin
      if (!i_reset_n || (rst_low_at.exists(n) && rst_low_at[n])) begin
        m_active = 0; m_armed = 0; m_hf = 0; m_high = 0; m_low = 0;
        m_errp = 0; m_errs = 0;
        for (int j = n - 3; j <= n; j++) if (trans.exists(j)) trans.delete(j);
      end else begin
        en    = en_at.exists(n) ? en_at[n] : 1'b0;
        clr   = clr_at.exists(n) ? clr_at[n] : 1'b0;
        has_e = trans.exists(n - 3);
        is_r  = has_e && trans[n - 3];
        if (!en) begin
          m_active = 0; m_armed = 0;
        end else if (!m_active) begin
          m_active = 1; m_armed = 0; m_ref_t = n; m_ref_v = 0;
        end else begin
          cnt_b = m_ref_v + (n - 1 - m_ref_t);
          if (cnt_b > M_CMAX) cnt_b = M_CMAX;
          if (has_e) begin
            e_rise = is_r; e_fall = !is_r;
            m_ref_t = n; m_ref_v = 1;
            if (is_r) begin
              if (m_armed && m_hf) begin
                e_meas = 1;
                m_low  = n - m_fall_t;
                if (off_tol(m_high) || off_tol(m_low)) setp = 1;
              end
              m_armed = 1; m_rise_t = n; m_hf = 0;
            end else if (m_armed) begin
              m_high = n - m_rise_t; m_fall_t = n; m_hf = 1;
            end
          end else if (cnt_b == M_TIMEOUT) begin
            sets = 1; m_armed = 0; m_ref_t = n; m_ref_v = 0;
          end
        end
        m_errp = setp ? 1'b1 : (clr ? 1'b0 : m_errp);
        m_errs = sets ? 1'b1 : (clr ? 1'b0 : m_errs);
      end
      check("rise", 32'(o_rise), 32'(e_rise));
      check("fall", 32'(o_fall), 32'(e_fall));
      check("meas_valid", 32'(o_meas_valid), 32'(e_meas));
      check("high_cnt", 32'(o_high_cnt), 32'(m_high));
      check("low_cnt", 32'(o_low_cnt), 32'(m_low));
      check("err_period", 32'(o_err_period), 32'(m_errp));
      check("err_stuck", 32'(o_err_stuck), 32'(m_errs));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int m0, off_len, rem;
    hold(3);
    check("rst_high_cnt", 32'(o_high_cnt), 32'd0);
    check("rst_err_stuck", 32'(o_err_stuck), 32'd0);
    cur_rstn = 1'b1;
    hold(2);

    // Divide-by-12 source, nominal periods.
    cur_en = 1'b1;
    half(1'b0, 4);
    repeat (8) begin half(1'b1, 6); half(1'b0, 6); end
    m0 = meas_seen;
    repeat (4) begin half(1'b1, 6); half(1'b0, 6); end
    check("d12_meas_per_48", 32'(meas_seen - m0), 32'd4);
    check("d12_high", 32'(o_high_cnt), 32'd6);
    check("d12_low", 32'(o_low_cnt), 32'd6);
    check("d12_err_period", 32'(o_err_period), 32'd0);
    check("d12_err_stuck", 32'(o_err_stuck), 32'd0);

    // Divide-by-8 source: half-period 4 violates 6+/-1; flag is sticky until cleared.
    repeat (3) begin half(1'b1, 4); half(1'b0, 4); end
    half(1'b1, 6);
    check("d8_err_set", 32'(o_err_period), 32'd1);
    half(1'b0, 6); half(1'b1, 6);
    check("d8_err_sticky", 32'(o_err_period), 32'd1);
    half(1'b0, 3); cur_clr = 1'b1; hold(1); cur_clr = 1'b0; hold(2);
    check("d8_err_cleared", 32'(o_err_period), 32'd0);

    // Clear arriving in the very cycle a period error is detected.
    sched_clr_on_rise = 1'b1;
    half(1'b1, 4); half(1'b0, 4);
    half(1'b1, 1);
    sched_clr_on_rise = 1'b0;
    hold(5);
    check("set_beats_clr", 32'(o_err_period), 32'd1);

    // Input stuck high.
    half(1'b0, 6);
    half(1'b1, 50);
    check("stuck_set", 32'(o_err_stuck), 32'd1);
    half(1'b0, 5); cur_clr = 1'b1; hold(1); cur_clr = 1'b0; hold(1);
    check("stuck_cleared", 32'(o_err_stuck), 32'd0);
    check("period_cleared", 32'(o_err_period), 32'd0);

    // Enable dropped in the middle of a low phase.
    half(1'b1, 6); half(1'b0, 6);
    half(1'b1, 5); half(1'b0, 7); half(1'b1, 6);
    m0 = meas_seen;
    half(1'b0, 3); cur_en = 1'b0; hold(3); cur_en = 1'b1; hold(3);
    check("endrop_high_held", 32'(o_high_cnt), 32'd5);
    check("endrop_low_held", 32'(o_low_cnt), 32'd7);
    half(1'b1, 6); half(1'b0, 6);
    check("endrop_no_meas", 32'(meas_seen - m0), 32'd0);
    check("endrop_low_still", 32'(o_low_cnt), 32'd7);
    half(1'b1, 6); half(1'b0, 6);
    check("endrop_meas_resumed", 32'(meas_seen - m0), 32'd1);

    // Asynchronous reset during a high phase.
    half(1'b1, 4);
    cur_rstn = 1'b0; drive_cycle(); #1;
    check("arst_high_cnt", 32'(o_high_cnt), 32'd0);
    check("arst_low_cnt", 32'(o_low_cnt), 32'd0);
    check("arst_err", 32'(o_err_period), 32'd0);
    hold(1); cur_rstn = 1'b1; hold(2);
    m0 = meas_seen;
    half(1'b0, 6);
    check("arst_no_early_meas", 32'(meas_seen - m0), 32'd0);
    half(1'b1, 6); half(1'b0, 6); half(1'b1, 6);

    // Randomized waveforms with occasional enable drops, clears and stalls.
    off_len = 0; rem = 0;
    for (int i = 0; i < 900; i++) begin
      if (rem == 0) begin
        cur_div = ~cur_div;
        rem = ($urandom_range(0, 19) == 0) ? int'($urandom_range(22, 30))
                                           : int'($urandom_range(3, 10));
      end
      rem--;
      if (off_len > 0) off_len--;
      else if ($urandom_range(0, 99) == 0) off_len = $urandom_range(1, 8);
      cur_en  = (off_len == 0);
      cur_clr = ($urandom_range(0, 31) == 0);
      drive_cycle();
    end
    cur_clr = 1'b0;
    hold(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_mon.md
CLK_DIV_MON -- requirements
Module: clk_div_mon

Interface
REQ-001 Parameter: EXP_HALF, default 6, expected half-period of the monitored divided clock, in i_clk cycles.
REQ-002 Parameter: TOL, default 0, allowed absolute deviation of each measured half-period from EXP_HALF.
REQ-003 Parameter: CNT_WIDTH, default 8, width of the run counter and the measurement outputs.
REQ-004 Parameter: TIMEOUT, default 255, run-counter value that declares the input stuck; TIMEOUT SHALL be ≤ 2^CNT_WIDTH-1.
REQ-005 i_clk  input  1  monitor clock, rising-edge active.
REQ-006 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-007 i_en  input  1  monitor enable, level.
REQ-008 i_div_clk  input  1  divided clock under test, treated as asynchronous to i_clk.
REQ-009 i_clr_err  input  1  clears sticky error flags, single-cycle pulse or level.
REQ-010 o_rise  output  1  one-cycle strobe per synchronized rising edge of i_div_clk.
REQ-011 o_fall  output  1  one-cycle strobe per synchronized falling edge of i_div_clk.
REQ-012 o_high_cnt  output  CNT_WIDTH  last measured high-phase length, in i_clk cycles.
REQ-013 o_low_cnt  output  CNT_WIDTH  last measured low-phase length, in i_clk cycles.
REQ-014 o_meas_valid  output  1  one-cycle strobe when a full high+low period has been measured.
REQ-015 o_err_period  output  1  sticky: a measured half-period fell outside EXP_HALF±TOL.
REQ-016 o_err_stuck  output  1  sticky: no edge was seen within TIMEOUT cycles.

Function
REQ-017 Sync: i_div_clk SHALL pass through a 2-flop synchronizer followed by a history flop; edges are derived from the synchronizer output and the history flop.
REQ-018 Edge latency: o_rise/o_fall SHALL be registered and assert exactly 3 i_clk rising edges after the first i_clk edge that samples the new i_div_clk level, for 1 cycle.
REQ-019 o_rise/o_fall SHALL pulse whenever i_en=1, in every FSM state except IDLE; both SHALL be 0 when i_en=0.
REQ-020 FSM states: IDLE, SYNC, HIGH, LOW.
REQ-021 IDLE→SYNC when i_en=1; any state→IDLE when i_en=0; an i_en drop takes priority over every other transition in the same cycle.
REQ-022 SYNC→HIGH on a synchronized rise; the partial phase before the first rise SHALL be discarded and never reported.
REQ-023 HIGH→LOW on a synchronized fall: o_high_cnt ← run counter.
REQ-024 LOW→HIGH on a synchronized rise: o_low_cnt ← run counter, o_meas_valid=1 for that cycle.
REQ-025 Run counter: loaded with 1 on each synchronized edge, +1 per cycle otherwise, saturating at 2^CNT_WIDTH-1, held at 0 in IDLE. The value captured at an edge equals the i_clk cycles between consecutive edges.
REQ-026 Period check: in the o_meas_valid cycle, o_err_period SHALL set if |o_high_cnt−EXP_HALF|>TOL or |o_low_cnt−EXP_HALF|>TOL, using the newly captured values.
REQ-027 Stuck: in SYNC, HIGH or LOW, when the run counter equals TIMEOUT with no edge, o_err_stuck SHALL set, the FSM SHALL go to SYNC and the counter SHALL reload to 0.
REQ-028 o_high_cnt/o_low_cnt SHALL hold their last values through IDLE and SYNC.
REQ-029 Sticky flags SHALL clear on i_clr_err=1; when a set and a clear occur in the same cycle, set wins.
REQ-030 The block SHALL NOT use i_div_clk as a clock; all flops are on i_clk.

Reset
REQ-031 Asserting i_reset_n=0 SHALL immediately force: FSM=IDLE, synchronizer/history=0, run counter=0, o_rise=o_fall=o_meas_valid=0, o_high_cnt=o_low_cnt=0, o_err_period=o_err_stuck=0.
REQ-032 Reset mid-measurement SHALL discard the partial period; after release the first o_meas_valid SHALL require a full SYNC→HIGH→LOW→HIGH sequence.

Verification
REQ-033 Divide-by-12 source (toggles every 6 i_clk), defaults, i_en=1 → o_high_cnt=6, o_low_cnt=6, o_meas_valid every 12 cycles, both error flags 0.
REQ-034 Divide-by-8 source (half=4), EXP_HALF=6, TOL=0 → o_err_period=1 at the first o_meas_valid; it stays 1 until an i_clr_err pulse; with TOL=2 it stays 0.
REQ-035 i_div_clk held high, TIMEOUT=20 → o_err_stuck=1 exactly when the run counter reaches 20, FSM in SYNC, no o_meas_valid.
REQ-036 i_en dropped in the middle of the LOW phase, then restored → no o_meas_valid for the interrupted period; o_high_cnt/o_low_cnt keep their prior values until the next full period.
REQ-037 i_clr_err asserted in the same cycle that a period error is detected → o_err_period=1 afterwards.
REQ-038 i_reset_n pulsed low during HIGH → all outputs 0 asynchronously; the first o_meas_valid occurs no earlier than the second synchronized rise after release.
